// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the shift-and-add-3 correction constants.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_WIDTH = 4;

    localparam logic [BCD_DIGIT_WIDTH-1:0] BCD_CORRECT_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_WIDTH-1:0] BCD_CORRECT_ADD       = 4'd3;

endpackage

// File: rtl/bcd_digit_shift_stage.sv
// One BCD digit of the double-dabble datapath: add-3 correction, then a
// one-bit left shift with the shifted-out bit presented as carry_out.
module bcd_digit_shift_stage
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_WIDTH-1:0] digit,
    input  logic                       carry_in,
    output logic [BCD_DIGIT_WIDTH-1:0] digit_out,
    output logic                       carry_out
);

    logic [BCD_DIGIT_WIDTH-1:0] corrected;

    // Pre-shift digit is at most 9, so the 4-bit add never carries out.
    always_comb begin
        corrected = digit;
        if (digit >= BCD_CORRECT_THRESHOLD) begin
            corrected = digit + BCD_CORRECT_ADD;
        end
        digit_out = {corrected[BCD_DIGIT_WIDTH-2:0], carry_in};
        carry_out = corrected[BCD_DIGIT_WIDTH-1];
    end

endmodule

// File: rtl/bin2bcd_sequential_converter.sv
// Multi-cycle binary-to-BCD converter (double dabble), one operand bit per
// clock, with optional signed input, sticky overflow and start/ready/done.
module bin2bcd_sequential_converter
    import bin2bcd_pkg::*;
#(
    parameter int unsigned INPUT_BIT_WIDTH = 8,
    parameter int unsigned DIGITS          = 3,
    parameter int unsigned SIGNED_MODE     = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [INPUT_BIT_WIDTH-1:0]      bin,
    output logic                            ready,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_WIDTH*DIGITS-1:0] digits,
    output logic                            negative,
    output logic                            overflow
);

    localparam int unsigned CNT_W = $clog2(INPUT_BIT_WIDTH + 1);
    localparam int unsigned BCD_W = BCD_DIGIT_WIDTH * DIGITS;

    state_t                     state;
    state_t                     state_next;
    logic                       accept;
    logic                       last_shift;

    logic [INPUT_BIT_WIDTH-1:0] shreg;
    logic [BCD_W-1:0]           bcd;
    logic [BCD_W-1:0]           bcd_next;
    logic [DIGITS:0]            carry;
    logic [CNT_W-1:0]           cnt;
    logic                       ovf_work;
    logic                       ovf_next;
    logic                       neg_pend;

    logic                       sign_in;
    logic [INPUT_BIT_WIDTH-1:0] magnitude;

    // Negating the most negative value wraps to 2^(W-1), which is the
    // correct magnitude when read back as unsigned.
    always_comb begin
        sign_in   = (SIGNED_MODE != 0) && bin[INPUT_BIT_WIDTH-1];
        magnitude = sign_in ? -bin : bin;
    end

    assign carry[0] = shreg[INPUT_BIT_WIDTH-1];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_shift_stage u_stage (
            .digit     (bcd[k*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
            .carry_in  (carry[k]),
            .digit_out (bcd_next[k*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
            .carry_out (carry[k+1])
        );
    end

    assign ovf_next = ovf_work | carry[DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_shift = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    last_shift = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Results are captured on the final shift so they appear with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_work <= 1'b0;
            neg_pend <= 1'b0;
            digits   <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            shreg    <= magnitude;
            bcd      <= '0;
            cnt      <= CNT_W'(INPUT_BIT_WIDTH);
            ovf_work <= 1'b0;
            neg_pend <= sign_in;
        end else if (state == SHIFT) begin
            shreg    <= {shreg[INPUT_BIT_WIDTH-2:0], 1'b0};
            bcd      <= bcd_next;
            cnt      <= cnt - CNT_W'(1);
            ovf_work <= ovf_next;
            if (last_shift) begin
                digits   <= bcd_next;
                negative <= neg_pend;
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_sequential_converter.sv
// Scoreboard bench: four converter configurations, expectations queued at
// acceptance and compared (value and arrival cycle) when done pulses.
module tb_bin2bcd_sequential_converter;

    typedef struct {
        logic [19:0] digits;
        logic        neg;
        logic        ovf;
        int unsigned due;
    } exp_t;

    logic clk;
    logic rst;
    int unsigned cyc;
    int unsigned tests;
    int unsigned fails;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t qd[$];

    // A: W=8 D=3 unsigned
    logic        start_a, ready_a, busy_a, done_a, neg_a, ovf_a;
    logic [7:0]  bin_a;
    logic [11:0] digits_a;
    // B: W=8 D=3 signed
    logic        start_b, ready_b, busy_b, done_b, neg_b, ovf_b;
    logic [7:0]  bin_b;
    logic [11:0] digits_b;
    // C: W=8 D=2 unsigned
    logic        start_c, ready_c, busy_c, done_c, neg_c, ovf_c;
    logic [7:0]  bin_c;
    logic [7:0]  digits_c;
    // D: W=16 D=5 unsigned
    logic        start_d, ready_d, busy_d, done_d, neg_d, ovf_d;
    logic [15:0] bin_d;
    logic [19:0] digits_d;

    bin2bcd_sequential_converter #(.INPUT_BIT_WIDTH(8), .DIGITS(3), .SIGNED_MODE(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .ready(ready_a), .busy(busy_a),
        .done(done_a), .digits(digits_a), .negative(neg_a), .overflow(ovf_a));
    bin2bcd_sequential_converter #(.INPUT_BIT_WIDTH(8), .DIGITS(3), .SIGNED_MODE(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .ready(ready_b), .busy(busy_b),
        .done(done_b), .digits(digits_b), .negative(neg_b), .overflow(ovf_b));
    bin2bcd_sequential_converter #(.INPUT_BIT_WIDTH(8), .DIGITS(2), .SIGNED_MODE(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .ready(ready_c), .busy(busy_c),
        .done(done_c), .digits(digits_c), .negative(neg_c), .overflow(ovf_c));
    bin2bcd_sequential_converter #(.INPUT_BIT_WIDTH(16), .DIGITS(5), .SIGNED_MODE(0)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .bin(bin_d), .ready(ready_d), .busy(busy_d),
        .done(done_d), .digits(digits_d), .negative(neg_d), .overflow(ovf_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #1_500_000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Decimal reference: low nd digits of mag, overflow if anything remains.
    function automatic exp_t model(input int unsigned mag, input logic neg,
                                   input int unsigned nd, input int unsigned due);
        exp_t e;
        int unsigned m;
        m = mag;
        e.digits = '0;
        for (int unsigned k = 0; k < nd; k++) begin
            e.digits[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.neg = neg;
        e.ovf = (m != 0);
        e.due = due;
        return e;
    endfunction

    logic pd_a, pd_b, pd_c, pd_d;
    initial begin pd_a = 0; pd_b = 0; pd_c = 0; pd_d = 0; end

    always @(negedge clk) begin
        exp_t e;
        if (pd_a) check("a_done_width", done_a, 0);
        if (done_a) begin
            check("a_expected_done", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_digits", digits_a, e.digits[11:0]);
                check("a_negative", neg_a, e.neg);
                check("a_overflow", ovf_a, e.ovf);
                check("a_latency", cyc, e.due);
            end
        end
        pd_a = done_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pd_b) check("b_done_width", done_b, 0);
        if (done_b) begin
            check("b_expected_done", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_digits", digits_b, e.digits[11:0]);
                check("b_negative", neg_b, e.neg);
                check("b_overflow", ovf_b, e.ovf);
                check("b_latency", cyc, e.due);
            end
        end
        pd_b = done_b;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pd_c) check("c_done_width", done_c, 0);
        if (done_c) begin
            check("c_expected_done", qc.size() != 0, 1);
            if (qc.size() != 0) begin
                e = qc.pop_front();
                check("c_digits", digits_c, e.digits[7:0]);
                check("c_negative", neg_c, e.neg);
                check("c_overflow", ovf_c, e.ovf);
                check("c_latency", cyc, e.due);
            end
        end
        pd_c = done_c;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pd_d) check("d_done_width", done_d, 0);
        if (done_d) begin
            check("d_expected_done", qd.size() != 0, 1);
            if (qd.size() != 0) begin
                e = qd.pop_front();
                check("d_digits", digits_d, e.digits);
                check("d_negative", neg_d, e.neg);
                check("d_overflow", ovf_d, e.ovf);
                check("d_latency", cyc, e.due);
            end
        end
        pd_d = done_d;
    end

    task automatic drain(input int unsigned limit);
        int unsigned n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain", qa.size() + qb.size() + qc.size() + qd.size(), 0);
    endtask

    task automatic conv_a(input logic [7:0] v);
        @(negedge clk);
        check("a_ready", ready_a, 1);
        start_a = 1'b1;
        bin_a   = v;
        qa.push_back(model({24'b0, v}, 1'b0, 3, cyc + 1 + 8));
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = ~v;
        drain(40);
    endtask

    task automatic conv_b(input logic [7:0] v);
        int unsigned mag;
        mag = v[7] ? 256 - {24'b0, v} : {24'b0, v};
        @(negedge clk);
        check("b_ready", ready_b, 1);
        start_b = 1'b1;
        bin_b   = v;
        qb.push_back(model(mag, v[7], 3, cyc + 1 + 8));
        @(negedge clk);
        start_b = 1'b0;
        bin_b   = ~v;
        drain(40);
    endtask

    task automatic conv_c(input logic [7:0] v);
        @(negedge clk);
        check("c_ready", ready_c, 1);
        start_c = 1'b1;
        bin_c   = v;
        qc.push_back(model({24'b0, v}, 1'b0, 2, cyc + 1 + 8));
        @(negedge clk);
        start_c = 1'b0;
        bin_c   = ~v;
        drain(40);
    endtask

    initial begin
        logic [15:0] v;
        int unsigned g;
        tests = 0;
        fails = 0;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        bin_a = '0; bin_b = '0; bin_c = '0; bin_d = '0;
        rst = 1'b1;
        #1;
        check("rst_digits", digits_a, 0);
        check("rst_negative", neg_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_done", done_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        conv_a(8'd255);
        conv_a(8'd0);
        conv_a(8'd9);

        conv_b(8'h80);
        conv_b(8'h7F);
        conv_b(8'hFF);

        conv_c(8'd200);
        conv_c(8'd99);
        conv_c(8'd100);

        // Start held high with the operand changing every cycle.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start_a = 1'b1;
            bin_a   = 8'($urandom);
            if (ready_a) qa.push_back(model({24'b0, bin_a}, 1'b0, 3, cyc + 1 + 8));
        end
        @(negedge clk);
        start_a = 1'b0;
        drain(40);

        // Reset during the fourth shift cycle aborts the conversion.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'd123;
        qa.push_back(model(123, 1'b0, 3, cyc + 1 + 8));
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", busy_a, 1);
        check("abort_ready", ready_a, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_digits", digits_a, 0);
        check("abort_ready_rst", ready_a, 1);
        check("abort_busy_rst", busy_a, 0);
        check("abort_done_rst", done_a, 0);
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        conv_a(8'd42);

        // W=16 sweep: low range, top range, and a stride across the rest.
        g = 0;
        for (int unsigned i = 0; i < 2200; i++) begin
            if (i < 1024)      v = 16'(i);
            else if (i < 1524) v = 16'(65535 - (i - 1024));
            else               v = 16'((i - 1524) * 97);
            g = 0;
            while (!ready_d && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (!ready_d) check("d_ready_timeout", ready_d, 1);
            start_d = 1'b1;
            bin_d   = v;
            qd.push_back(model({16'b0, v}, 1'b0, 5, cyc + 1 + 16));
            @(negedge clk);
        end
        start_d = 1'b0;
        drain(60);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
